// File: rtl/int8_mac_feeder.sv
// Upstream sequencer for the pipelined INT8 MAC: accepts a job command and an operand
// stream, drives the MAC inputs, and closes the job on result-valid or drain timeout.
module int8_mac_feeder #(
    parameter int MO_WIDTH = 32,
    parameter int LEN_W    = 16,
    parameter int DRAIN_TO = 15
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [7:0]          cmd_Za,
    input  logic [7:0]          cmd_Zw,
    input  logic [7:0]          cmd_Zo,
    input  logic [MO_WIDTH-1:0] cmd_M0,
    input  logic [5:0]          cmd_n,
    input  logic [31:0]         cmd_bias,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_qa,
    input  logic [7:0]          in_qw,
    output logic                mac_En,
    output logic                mac_clear,
    output logic                mac_last,
    output logic [7:0]          mac_Qa,
    output logic [7:0]          mac_Qw,
    output logic [7:0]          mac_Za,
    output logic [7:0]          mac_Zw,
    output logic [7:0]          mac_Zo,
    output logic [MO_WIDTH-1:0] mac_M0,
    output logic [5:0]          mac_n,
    output logic [31:0]         mac_bias,
    input  logic                mac_q3_valid,
    output logic                busy,
    output logic                job_done,
    output logic                err_zero_len,
    output logic                err_timeout
);

    localparam int TMR_W = (DRAIN_TO < 2) ? 1 : $clog2(DRAIN_TO + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [7:0]          za_q, za_d, zw_q, zw_d, zo_q, zo_d;
    logic [MO_WIDTH-1:0] m0_q, m0_d;
    logic [5:0]          n_q, n_d;
    logic [31:0]         bias_q, bias_d;
    logic                en_q, en_d, clear_q, clear_d, last_q, last_d;
    logic [7:0]          qa_q, qa_d, qw_q, qw_d;
    logic                done_q, done_d, zl_q, zl_d, to_q, to_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        timer_d = timer_q;
        za_d    = za_q;
        zw_d    = zw_q;
        zo_d    = zo_q;
        m0_d    = m0_q;
        n_d     = n_q;
        bias_d  = bias_q;
        qa_d    = qa_q;
        qw_d    = qw_q;
        en_d    = 1'b0;
        clear_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        zl_d    = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    len_d  = cmd_len;
                    za_d   = cmd_Za;
                    zw_d   = cmd_Zw;
                    zo_d   = cmd_Zo;
                    m0_d   = cmd_M0;
                    n_d    = cmd_n;
                    bias_d = cmd_bias;
                    cnt_d  = '0;
                    if (cmd_len == '0) begin
                        zl_d   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (in_valid) begin
                    en_d    = 1'b1;
                    qa_d    = in_qa;
                    qw_d    = in_qw;
                    clear_d = (cnt_q == '0);
                    last_d  = (cnt_q == len_q - LEN_W'(1));
                    cnt_d   = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_DRAIN;
                        timer_d = TMR_W'(DRAIN_TO);
                    end
                end
            end
            S_DRAIN: begin
                // A result arriving on the final timer cycle still counts as a normal close.
                if (mac_q3_valid) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (timer_q <= TMR_W'(1)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    to_d    = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            timer_q <= '0;
            za_q    <= '0;
            zw_q    <= '0;
            zo_q    <= '0;
            m0_q    <= '0;
            n_q     <= '0;
            bias_q  <= '0;
            qa_q    <= '0;
            qw_q    <= '0;
            en_q    <= 1'b0;
            clear_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            zl_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            timer_q <= timer_d;
            za_q    <= za_d;
            zw_q    <= zw_d;
            zo_q    <= zo_d;
            m0_q    <= m0_d;
            n_q     <= n_d;
            bias_q  <= bias_d;
            qa_q    <= qa_d;
            qw_q    <= qw_d;
            en_q    <= en_d;
            clear_q <= clear_d;
            last_q  <= last_d;
            done_q  <= done_d;
            zl_q    <= zl_d;
            to_q    <= to_d;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign in_ready     = (state_q == S_STREAM);
    assign busy         = (state_q != S_IDLE);
    assign mac_En       = en_q;
    assign mac_clear    = clear_q;
    assign mac_last     = last_q;
    assign mac_Qa       = qa_q;
    assign mac_Qw       = qw_q;
    assign mac_Za       = za_q;
    assign mac_Zw       = zw_q;
    assign mac_Zo       = zo_q;
    assign mac_M0       = m0_q;
    assign mac_n        = n_q;
    assign mac_bias     = bias_q;
    assign job_done     = done_q;
    assign err_zero_len = zl_q;
    assign err_timeout  = to_q;

endmodule

// File: tb/tb_int8_mac_feeder.sv
// Directed bench for int8_mac_feeder; a delay line stands in for the MAC result-valid.
module tb_int8_mac_feeder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_len;
    logic [7:0]  cmd_Za, cmd_Zw, cmd_Zo;
    logic [31:0] cmd_M0;
    logic [5:0]  cmd_n;
    logic [31:0] cmd_bias;
    logic        in_valid, in_ready;
    logic [7:0]  in_qa, in_qw;
    logic        mac_En, mac_clear, mac_last;
    logic [7:0]  mac_Qa, mac_Qw, mac_Za, mac_Zw, mac_Zo;
    logic [31:0] mac_M0;
    logic [5:0]  mac_n;
    logic [31:0] mac_bias;
    logic        mac_q3_valid;
    logic        busy, job_done, err_zero_len, err_timeout;

    int checks = 0;
    int errors = 0;
    int idx, n_en, n_clear, n_last, clear_idx, last_idx;
    int n_done, done_idx, n_zl, zl_idx, n_to, to_idx, q3_idx, viol, acc;
    longint q3;
    logic [31:0] en_pat;
    logic [7:0]  pipe, prev_qa, prev_qw;
    logic        q3_en;

    int8_mac_feeder #(.MO_WIDTH(32), .LEN_W(16), .DRAIN_TO(15)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_Za(cmd_Za), .cmd_Zw(cmd_Zw), .cmd_Zo(cmd_Zo), .cmd_M0(cmd_M0),
        .cmd_n(cmd_n), .cmd_bias(cmd_bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_qa(in_qa), .in_qw(in_qw),
        .mac_En(mac_En), .mac_clear(mac_clear), .mac_last(mac_last),
        .mac_Qa(mac_Qa), .mac_Qw(mac_Qw), .mac_Za(mac_Za), .mac_Zw(mac_Zw),
        .mac_Zo(mac_Zo), .mac_M0(mac_M0), .mac_n(mac_n), .mac_bias(mac_bias),
        .mac_q3_valid(mac_q3_valid), .busy(busy), .job_done(job_done),
        .err_zero_len(err_zero_len), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        idx = 0; n_en = 0; n_clear = 0; n_last = 0; clear_idx = -1; last_idx = -1;
        n_done = 0; done_idx = -1; n_zl = 0; zl_idx = -1; n_to = 0; to_idx = -1;
        q3_idx = -1; viol = 0; acc = 0; en_pat = '0;
    endtask

    // Samples one cycle #1 after the edge, then updates the emulated MAC result-valid.
    task automatic step();
        @(posedge CLK);
        #1;
        if (mac_En) begin
            if (idx < 32) en_pat[idx] = 1'b1;
            if (mac_clear) begin n_clear++; clear_idx = idx; end
            if (mac_last) begin n_last++; last_idx = idx; end
            acc = acc + int'($signed(mac_Qa)) * int'($signed(mac_Qw));
            n_en++;
            prev_qa = mac_Qa;
            prev_qw = mac_Qw;
        end else begin
            if (mac_clear || mac_last) viol++;
            if (n_en > 0 && (mac_Qa !== prev_qa || mac_Qw !== prev_qw)) viol++;
        end
        if (job_done) begin n_done++; done_idx = idx; end
        if (err_zero_len) begin n_zl++; zl_idx = idx; end
        if (err_timeout) begin n_to++; to_idx = idx; end
        pipe = {pipe[6:0], mac_En & mac_last};
        mac_q3_valid = q3_en & pipe[7];
        if (mac_q3_valid) q3_idx = idx;
        idx++;
    endtask

    task automatic send_cmd(input logic [15:0] len, input logic [7:0] za, input logic [7:0] zw,
                            input logic [7:0] zo, input logic [31:0] m0, input logic [5:0] n,
                            input logic [31:0] bias);
        cmd_valid = 1'b1; cmd_len = len; cmd_Za = za; cmd_Zw = zw; cmd_Zo = zo;
        cmd_M0 = m0; cmd_n = n; cmd_bias = bias;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 40 && n_done == 0; k++) step();
        chk(tag, 64'(n_done), 64'd1);
    endtask

    initial begin
        RST = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_Za = '0; cmd_Zw = '0; cmd_Zo = '0;
        cmd_M0 = '0; cmd_n = '0; cmd_bias = '0; in_valid = 1'b0; in_qa = '0; in_qw = '0;
        mac_q3_valid = 1'b0; q3_en = 1'b1; pipe = '0; prev_qa = '0; prev_qw = '0;
        clear_stats();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_outs", 64'({mac_En, mac_clear, mac_last, job_done, err_zero_len, err_timeout}), 64'd0);
        chk("rst_m0", 64'(mac_M0), 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        // Test 1: four pairs back-to-back
        clear_stats();
        send_cmd(16'd4, 8'd0, 8'd0, 8'd0, 32'h4000_0000, 6'd0, 32'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        chk("t1_cmd_ready", 64'(cmd_ready), 64'd0);
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_qa = 8'(i); in_qw = 8'(i);
            step();
        end
        in_valid = 1'b0;
        wait_done("t1_done_seen");
        chk("t1_n_en", 64'(n_en), 64'd4);
        chk("t1_en_pat", 64'(en_pat), 64'h1E);
        chk("t1_clear_idx", 64'(clear_idx), 64'd1);
        chk("t1_last_idx", 64'(last_idx), 64'd4);
        chk("t1_n_clear_last", 64'({n_clear[7:0], n_last[7:0]}), 64'h0101);
        chk("t1_acc", 64'(acc), 64'd30);
        q3 = (longint'(acc) * longint'($signed(mac_M0))) >>> 31;
        chk("t1_q3", 64'(q3), 64'd15);
        chk("t1_done_lag", 64'(done_idx - q3_idx), 64'd1);
        chk("t1_done_idx", 64'(done_idx), 64'd12);
        chk("t1_no_timeout", 64'(n_to), 64'd0);
        chk("t1_viol", 64'(viol), 64'd0);
        chk("t1_idle", 64'({busy, cmd_ready}), 64'b01);

        // Test 2: same job with bubbles between pairs
        clear_stats();
        send_cmd(16'd4, 8'd0, 8'd0, 8'd0, 32'h4000_0000, 6'd0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_qa = 8'(i); in_qw = 8'(i);
            step();
            in_valid = 1'b0;
            step();
        end
        wait_done("t2_done_seen");
        chk("t2_en_pat", 64'(en_pat), 64'hAA);
        chk("t2_clear_idx", 64'(clear_idx), 64'd1);
        chk("t2_last_idx", 64'(last_idx), 64'd7);
        chk("t2_acc", 64'(acc), 64'd30);
        chk("t2_viol", 64'(viol), 64'd0);
        chk("t2_done_idx", 64'(done_idx), 64'd15);

        // Test 3: single-pair job, clear and last on one beat
        clear_stats();
        send_cmd(16'd1, 8'd0, 8'd0, 8'd5, 32'd123, 6'd7, 32'hFFFF_FC18);
        in_valid = 1'b1; in_qa = 8'h80; in_qw = 8'h80;
        step();
        in_valid = 1'b0;
        wait_done("t3_done_seen");
        chk("t3_n_en", 64'(n_en), 64'd1);
        chk("t3_clear_last_idx", 64'({clear_idx[7:0], last_idx[7:0]}), 64'h0101);
        chk("t3_acc", 64'(acc), 64'd16384);
        chk("t3_params", 64'({mac_Za, mac_Zw, mac_Zo, mac_n}), 64'({8'd0, 8'd0, 8'd5, 6'd7}));
        chk("t3_m0", 64'(mac_M0), 64'd123);
        chk("t3_bias", 64'(mac_bias), 64'hFFFF_FC18);

        // Test 4: zero-length job
        clear_stats();
        send_cmd(16'd0, 8'd0, 8'd0, 8'd0, 32'd1, 6'd0, 32'd0);
        chk("t4_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        chk("t4_zl", 64'({n_zl[7:0], zl_idx[7:0]}), 64'h0100);
        chk("t4_done", 64'({n_done[7:0], done_idx[7:0]}), 64'h0100);
        chk("t4_n_en", 64'(n_en), 64'd0);

        // Test 5: no result returns, drain times out
        clear_stats();
        q3_en = 1'b0;
        send_cmd(16'd2, 8'd0, 8'd0, 8'd0, 32'd1, 6'd0, 32'd0);
        in_valid = 1'b1; in_qa = 8'd3; in_qw = 8'd4;
        repeat (2) step();
        in_valid = 1'b0;
        wait_done("t5_done_seen");
        chk("t5_last_idx", 64'(last_idx), 64'd2);
        chk("t5_to", 64'({n_to[7:0], to_idx[7:0]}), 64'h0111);
        chk("t5_done_idx", 64'(done_idx), 64'd17);
        chk("t5_idle", 64'({busy, cmd_ready}), 64'b01);
        q3_en = 1'b1;

        // Test 6: reset asserted mid-job, then a fresh job
        clear_stats();
        send_cmd(16'd5, 8'd1, 8'd2, 8'd3, 32'd77, 6'd4, 32'd9);
        in_valid = 1'b1; in_qa = 8'd9; in_qw = 8'd9;
        repeat (2) step();
        in_valid = 1'b0;
        #2 RST = 1'b0;
        #1;
        pipe = '0; mac_q3_valid = 1'b0;
        chk("t6_rst_ctrl", 64'({busy, cmd_ready, in_ready, job_done}), 64'b0100);
        chk("t6_rst_mac", 64'({mac_En, mac_clear, mac_last, mac_Qa, mac_Qw}), 64'd0);
        chk("t6_rst_params", 64'({mac_M0, mac_Za, mac_n}), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        step();
        chk("t6_post_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t6_no_done", 64'(n_done), 64'd0);
        clear_stats();
        send_cmd(16'd3, 8'd0, 8'd0, 8'd0, 32'h4000_0000, 6'd0, 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_qa = 8'(2 * i + 1); in_qw = 8'(2 * i + 2);
            step();
        end
        in_valid = 1'b0;
        wait_done("t6_done_seen");
        chk("t6_n_en", 64'(n_en), 64'd3);
        chk("t6_acc", 64'(acc), 64'd44);
        chk("t6_clear_last", 64'({clear_idx[7:0], last_idx[7:0]}), 64'h0103);
        chk("t6_no_timeout", 64'(n_to), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
